// File: rtl/servo_pkg.sv
// servo_pkg: shared timing defaults and width helpers for the servo PWM bank.
//   DEF_*        default frame/pulse timing in clk cycles at 50 MHz
//   clamp_width  limit a requested width to [lo, hi]
//   slew_step    move a width toward its target by at most 'step' (0 = jump)
//   ch_idx_w     bit width of a channel index for n channels
package servo_pkg;

  localparam int DEF_PERIOD = 1000000;   // 20 ms frame
  localparam int DEF_MIN    = 50000;     // 1.0 ms
  localparam int DEF_MAX    = 100000;    // 2.0 ms
  localparam int DEF_CENTER = 75000;     // 1.5 ms

  function automatic logic [31:0] clamp_width(input logic [31:0] w,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    logic [31:0] r;
    if (w < lo)      r = lo;
    else if (w > hi) r = hi;
    else             r = w;
    return r;
  endfunction

  // Both operands are already clamped into [MIN, MAX], so the unsigned
  // difference taken in the direction of the compare cannot wrap.
  function automatic logic [31:0] slew_step(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [31:0] step);
    logic [31:0] r;
    logic [31:0] diff;
    if (step == 32'd0) begin
      r = tgt;
    end else if (tgt >= cur) begin
      diff = tgt - cur;
      r    = (diff > step) ? cur + step : tgt;
    end else begin
      diff = cur - tgt;
      r    = (diff > step) ? cur - step : tgt;
    end
    return r;
  endfunction

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/servo_chan.sv
// servo_chan: one servo channel of the PWM bank.
//   clk, rst_n  clock and async active-low reset
//   wr_en       load a new target (already decoded for this channel)
//   wr_width    requested width, clamped here before it is stored
//   boundary    last cycle of the frame; applied width steps toward target
//   enable      0 forces the output low on the next cycle
//   count       shared frame counter
//   pwm         registered pulse output
//   match       applied width equals target
module servo_chan
  import servo_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int MIN_PULSE    = DEF_MIN,
  parameter int MAX_PULSE    = DEF_MAX,
  parameter int CENTER_PULSE = DEF_CENTER,
  parameter int SLEW_STEP    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_width,
  input  logic             boundary,
  input  logic             enable,
  input  logic [CNT_W-1:0] count,
  output logic             pwm,
  output logic             match
);

  localparam logic [31:0] MIN_W  = 32'(MIN_PULSE);
  localparam logic [31:0] MAX_W  = 32'(MAX_PULSE);
  localparam logic [31:0] SLEW_W = 32'(SLEW_STEP);

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] applied;
  logic [CNT_W-1:0] target_clamped;
  logic [CNT_W-1:0] applied_next;

  assign target_clamped = CNT_W'(clamp_width(32'(wr_width), MIN_W, MAX_W));
  assign applied_next   = CNT_W'(slew_step(32'(applied), 32'(target), SLEW_W));
  assign match          = (applied == target);

  // applied only changes on the boundary cycle, so a pulse in flight is never
  // shortened or stretched by a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target  <= CNT_W'(CENTER_PULSE);
      applied <= CNT_W'(CENTER_PULSE);
      pwm     <= 1'b0;
    end else begin
      if (wr_en)    target  <= target_clamped;
      if (boundary) applied <= applied_next;
      pwm <= enable && (count < applied);
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel servo PWM generator sharing one frame counter.
//   clk, rst_n   clock and async active-low reset
//   enable       1 = drive pulses, 0 = outputs low (counter keeps running)
//   wr_valid     write strobe; wr_ch selects channel, wr_width the high time
//   wr_ready     1 after reset, every write accepted in one cycle
//   wr_err       pulse: write addressed a nonexistent channel and was dropped
//   wr_clamped   pulse: write accepted but limited to MIN/MAX
//   pwm_out      registered pulse outputs, one per channel
//   frame_start  registered pulse, high the cycle after counter == 0
//   settled      registered, 1 when every applied width equals its target
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int NUM_CH        = 5,
  parameter int CNT_W         = 20,
  parameter int PERIOD_CYCLES = DEF_PERIOD,
  parameter int MIN_PULSE     = DEF_MIN,
  parameter int MAX_PULSE     = DEF_MAX,
  parameter int CENTER_PULSE  = DEF_CENTER,
  parameter int SLEW_STEP     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        wr_valid,
  input  logic [ch_idx_w(NUM_CH)-1:0] wr_ch,
  input  logic [CNT_W-1:0]            wr_width,
  output logic                        wr_ready,
  output logic                        wr_err,
  output logic                        wr_clamped,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        frame_start,
  output logic                        settled
);

  localparam int              CH_W = ch_idx_w(NUM_CH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0]  count;
  logic              boundary;
  logic              ch_ok;
  logic              clamp_hit;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] match;

  assign boundary  = (count == LAST);
  assign ch_ok     = ({{(32-CH_W){1'b0}}, wr_ch} < 32'(NUM_CH));
  assign clamp_hit = (clamp_width(32'(wr_width), 32'(MIN_PULSE), 32'(MAX_PULSE))
                      != 32'(wr_width));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = wr_valid && (wr_ch == CH_W'(i));

    servo_chan #(
      .CNT_W        (CNT_W),
      .MIN_PULSE    (MIN_PULSE),
      .MAX_PULSE    (MAX_PULSE),
      .CENTER_PULSE (CENTER_PULSE),
      .SLEW_STEP    (SLEW_STEP)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[i]),
      .wr_width (wr_width),
      .boundary (boundary),
      .enable   (enable),
      .count    (count),
      .pwm      (pwm_out[i]),
      .match    (match[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      frame_start <= 1'b0;
      wr_ready    <= 1'b0;
      wr_err      <= 1'b0;
      wr_clamped  <= 1'b0;
      settled     <= 1'b1;
    end else begin
      count       <= boundary ? '0 : count + 1'b1;
      frame_start <= (count == '0);
      wr_ready    <= 1'b1;
      wr_err      <= wr_valid && !ch_ok;
      wr_clamped  <= wr_valid && ch_ok && clamp_hit;
      settled     <= &match;
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
module tb_servo_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       wr_valid;
  logic [2:0] wr_ch;
  logic [19:0] wr_width;

  logic       wr_ready_a, wr_err_a, wr_clamped_a, frame_start_a, settled_a;
  logic [4:0] pwm_a;
  logic       wr_ready_s, wr_err_s, wr_clamped_s, frame_start_s, settled_s;
  logic [4:0] pwm_s;

  always #5 clk = ~clk;

  // Instance A: no slew limit. Instance S: slew of 2 cycles per frame.
  servo_pwm_bank #(.NUM_CH(5), .CNT_W(20), .PERIOD_CYCLES(100), .MIN_PULSE(10),
                   .MAX_PULSE(20), .CENTER_PULSE(15), .SLEW_STEP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ch(wr_ch),
    .wr_width(wr_width), .wr_ready(wr_ready_a), .wr_err(wr_err_a),
    .wr_clamped(wr_clamped_a), .pwm_out(pwm_a), .frame_start(frame_start_a),
    .settled(settled_a));

  servo_pwm_bank #(.NUM_CH(5), .CNT_W(20), .PERIOD_CYCLES(100), .MIN_PULSE(10),
                   .MAX_PULSE(20), .CENTER_PULSE(15), .SLEW_STEP(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ch(wr_ch),
    .wr_width(wr_width), .wr_ready(wr_ready_s), .wr_err(wr_err_s),
    .wr_clamped(wr_clamped_s), .pwm_out(pwm_s), .frame_start(frame_start_s),
    .settled(settled_s));

  typedef struct packed {
    logic [4:0][7:0] wa;
    logic [4:0][7:0] ws;
    logic            sa;
    logic            ss;
  } frame_t;

  frame_t     exp_q[$];
  logic [1:0] wexp_q[$];   // {err, clamped}
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0][7:0] w5(input int c0, input int c1, input int c2,
                                         input int c3, input int c4);
    logic [4:0][7:0] r;
    r[0] = c0[7:0]; r[1] = c1[7:0]; r[2] = c2[7:0]; r[3] = c3[7:0]; r[4] = c4[7:0];
    return r;
  endfunction

  task automatic push_frame(input logic [4:0][7:0] wa, input logic [4:0][7:0] ws,
                            input logic sa, input logic ss);
    frame_t f;
    f.wa = wa; f.ws = ws; f.sa = sa; f.ss = ss;
    exp_q.push_back(f);
  endtask

  task automatic do_write(input int ch, input int width, input logic e, input logic c);
    wr_valid = 1'b1;
    wr_ch    = ch[2:0];
    wr_width = width[19:0];
    wexp_q.push_back({e, c});
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic sync_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 250) begin
        errors++;
        checks++;
        $display("FAIL frame_start_timeout: actual none required within 250 cycles");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end while (!frame_start_a);
  endtask

  // ---------------- monitor ----------------
  logic wv_seen = 1'b0;
  always @(posedge clk) wv_seen <= wr_valid;

  int   cnt_a[5];
  int   cnt_s[5];
  int   flen = 0;
  int   fidx = 0;
  bit   started = 0;
  logic set_a, set_s;

  always @(negedge clk) begin
    frame_t     f;
    logic [1:0] w;
    if (!rst_n) begin
      started = 0;
    end else begin
      if (wv_seen) begin
        if (wexp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_resp: actual unexpected response required none queued");
        end else begin
          w = wexp_q.pop_front();
          chk("wr_err_a", wr_err_a, w[1]);
          chk("wr_clamped_a", wr_clamped_a, w[0]);
          chk("wr_err_s", wr_err_s, w[1]);
          chk("wr_clamped_s", wr_clamped_s, w[0]);
        end
      end else begin
        chk("wr_pulses_idle", {wr_err_a, wr_clamped_a, wr_err_s, wr_clamped_s}, 0);
      end

      if (frame_start_a) begin
        if (started) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame%0d_expect: actual frame seen required none queued", fidx);
          end else begin
            f = exp_q.pop_front();
            chk($sformatf("frame%0d_len", fidx), flen, 100);
            for (int i = 0; i < 5; i++) begin
              chk($sformatf("frame%0d_a_ch%0d_high", fidx, i), cnt_a[i], f.wa[i]);
              chk($sformatf("frame%0d_s_ch%0d_high", fidx, i), cnt_s[i], f.ws[i]);
            end
            chk($sformatf("frame%0d_a_settled", fidx), set_a, f.sa);
            chk($sformatf("frame%0d_s_settled", fidx), set_s, f.ss);
          end
          fidx++;
        end
        started = 1;
        flen    = 0;
        for (int i = 0; i < 5; i++) begin
          cnt_a[i] = 0;
          cnt_s[i] = 0;
        end
        set_a = settled_a;
        set_s = settled_s;
      end

      if (started) begin
        flen++;
        for (int i = 0; i < 5; i++) begin
          cnt_a[i] += int'(pwm_a[i]);
          cnt_s[i] += int'(pwm_s[i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b1; wr_valid = 1'b0; wr_ch = '0; wr_width = '0;
    repeat (3) @(negedge clk);
    chk("reset_wr_ready", {wr_ready_a, wr_ready_s}, 0);
    chk("reset_pwm", {pwm_a, pwm_s}, 0);
    chk("reset_frame_start", {frame_start_a, frame_start_s}, 0);
    chk("reset_settled", {settled_a, settled_s}, 3);
    chk("reset_wr_pulses", {wr_err_a, wr_clamped_a, wr_err_s, wr_clamped_s}, 0);
    rst_n = 1'b1;

    // F0: reset widths; mid-frame write ch2=12
    sync_frame(n);
    chk("first_frame_latency", n, 1);
    chk("wr_ready_after_reset", {wr_ready_a, wr_ready_s}, 3);
    push_frame(w5(15,15,15,15,15), w5(15,15,15,15,15), 1, 1);
    repeat (39) @(negedge clk);
    do_write(2, 12, 0, 0);

    // F1
    sync_frame(n);
    push_frame(w5(15,15,12,15,15), w5(15,15,13,15,15), 1, 0);

    // F2: clamp low, clamp high, out-of-range channel
    sync_frame(n);
    push_frame(w5(15,15,12,15,15), w5(15,15,12,15,15), 1, 1);
    repeat (10) @(negedge clk);
    do_write(0, 5, 0, 1);
    do_write(1, 30, 0, 1);
    do_write(7, 9, 1, 0);

    // F3: ch3 -> 20
    sync_frame(n);
    push_frame(w5(10,20,12,15,15), w5(13,17,12,15,15), 1, 0);
    repeat (10) @(negedge clk);
    do_write(3, 20, 0, 0);

    // F4..F6: slew walk on instance S
    sync_frame(n);
    push_frame(w5(10,20,12,20,15), w5(11,19,12,17,15), 1, 0);
    sync_frame(n);
    push_frame(w5(10,20,12,20,15), w5(10,20,12,19,15), 1, 0);
    sync_frame(n);
    push_frame(w5(10,20,12,20,15), w5(10,20,12,20,15), 1, 1);
    // write sampled on the counter==99 cycle
    repeat (98) @(negedge clk);
    do_write(4, 18, 0, 0);

    // F7: boundary kept old ch4 target
    sync_frame(n);
    push_frame(w5(10,20,12,20,15), w5(10,20,12,20,15), 0, 0);
    sync_frame(n);
    push_frame(w5(10,20,12,20,18), w5(10,20,12,20,17), 1, 0);
    sync_frame(n);
    push_frame(w5(10,20,12,20,18), w5(10,20,12,20,18), 1, 1);

    // F10: reset at counter 7 while outputs are high (frame aborted)
    sync_frame(n);
    repeat (6) @(negedge clk);
    chk("pre_reset_pwm_a", pwm_a, 5'h1f);
    chk("pre_reset_pwm_s", pwm_s, 5'h1f);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pwm", {pwm_a, pwm_s}, 0);
    chk("async_reset_wr_ready", {wr_ready_a, wr_ready_s}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // R0: counter restarts, enable low for 3 cycles
    sync_frame(n);
    chk("restart_latency", n, 1);
    push_frame(w5(12,12,12,12,12), w5(12,12,12,12,12), 1, 1);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("enable_low_pwm_%0d", k), {pwm_a, pwm_s}, 0);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("enable_resume_pwm", {pwm_a, pwm_s}, 10'h3ff);

    // R1
    sync_frame(n);
    push_frame(w5(15,15,15,15,15), w5(15,15,15,15,15), 1, 1);
    sync_frame(n);
    @(negedge clk);
    chk("frame_queue_drained", exp_q.size(), 0);
    chk("write_queue_drained", wexp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
